// File: rtl/req_arb_pkg.sv
// Shared constants, state encoding and helpers for the request arbiter.
package req_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index to one-hot conversion used when registering a grant.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/req_arbiter_prio_enc8.sv
// 8-to-3 priority encoder with a rotating start index.
// The search begins at 'start' and walks downwards (start, start-1, ...)
// wrapping modulo 8; the first set request wins.
import req_arb_pkg::*;

module prio_enc8 (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [ID_W-1:0]  id,
  output logic             found
);

  logic [ID_W-1:0] idx;

  // Walk from the lowest priority slot upwards so the last hit is the winner.
  always_comb begin
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = start - ID_W'(i);
      if (req[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Single-owner request arbiter with done/timeout release.
// Build option: define REQ_ARB_RR_EN for round-robin priority; otherwise
// requester 7 always has the highest fixed priority.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; grant the winning request when ena=1
// BUSY  | owner holds the grant until done or the timeout expires
import req_arb_pkg::*;

module req_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             tmo
);

  // A TIMEOUT of 0 disables forced release; the counter then just saturates.
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    start;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               grant_now;
  logic               tmo_hit;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               tmo_nxt;

  prio_enc8 u_enc (
    .req   (req),
    .start (start),
    .id    (win_id),
    .found (win_found)
  );

  assign grant_now = (state == IDLE) && ena && win_found;
  // Count value during the last allowed BUSY cycle without done.
  assign tmo_hit   = TMO_EN && (cnt == TMO_LAST);

`ifdef REQ_ARB_RR_EN
  logic [ID_W-1:0] ptr;

  // Remember the last granted index; search restarts just below it.
  always_ff @(posedge clk) begin
    if (!rst_n)         ptr <= '0;
    else if (grant_now) ptr <= win_id;
  end

  assign start = ptr - ID_W'(1);
`else
  assign start = ID_W'(N_REQ - 1);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: grant from IDLE, release on done or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_now)        state_nxt = BUSY;
      BUSY: if (done || tmo_hit)  state_nxt = IDLE;
    endcase
  end

  // Output/counter next values; everything leaves through registers.
  always_comb begin
    gnt_nxt = gnt;
    id_nxt  = gnt_id;
    tmo_nxt = 1'b0;
    cnt_nxt = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_now) begin
          gnt_nxt = id_to_onehot(win_id);
          id_nxt  = win_id;
        end else begin
          gnt_nxt = '0;
          id_nxt  = '0;
        end
      end
      BUSY: begin
        if (done) begin
          gnt_nxt = '0;
          id_nxt  = '0;
          cnt_nxt = '0;
        end else if (tmo_hit) begin
          gnt_nxt = '0;
          id_nxt  = '0;
          cnt_nxt = '0;
          tmo_nxt = 1'b1;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt    <= '0;
      gnt_id <= '0;
      tmo    <= 1'b0;
      cnt    <= '0;
    end else begin
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      tmo    <= tmo_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // The state flop is itself the registered valid flag.
  assign gnt_valid = (state == BUSY);

endmodule
